// File: rtl/mda_pkg.sv
// Shared definitions for the MDA character-fetch stage.
// Contents: default cell width, line-graphics code range, blank attribute,
// fetch deadline dot, and the fetch FSM state type.
package mda_pkg;

  localparam int CHAR_W_DEFAULT = 9;

  // Character codes whose ninth column repeats glyph bit 0.
  localparam logic [7:0] LINEGFX_LO = 8'hC0;
  localparam logic [7:0] LINEGFX_HI = 8'hDF;

  localparam logic [7:0] BLANK_ATTR = 8'h00;

  // If VRAM has not acknowledged by the dot_en of this dot, the slot goes blank.
  localparam logic [3:0] FETCH_DEADLINE_DOT = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FONT,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/mda_dot_shifter.sv
// CHAR_W-bit parallel-load / shift-left register producing the serial dot.
// Build option: MDA_LINEGFX_EN -- when defined, the ninth column copies glyph
// bit 0 for line-graphics codes 0xC0..0xDF; otherwise the ninth column is 0.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   load           load {glyph, col9} (wins over shift)
//   shift          shift left by one dot
//   glyph          glyph row, MSB = leftmost dot
//   char_code      character code of the glyph being loaded
//   pix            current dot (register MSB)
module mda_dot_shifter
  import mda_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] glyph,
  input  logic [7:0] char_code,
  output logic       pix
);

  logic              col9;
  logic [CHAR_W-1:0] load_val;
  logic [CHAR_W-1:0] sr;

`ifdef MDA_LINEGFX_EN
  // Box-drawing glyphs extend their rightmost dot so adjacent cells join.
  assign col9 = (char_code >= LINEGFX_LO && char_code <= LINEGFX_HI) ? glyph[0] : 1'b0;
`else
  logic unused_code;
  assign unused_code = ^char_code;
  assign col9        = 1'b0;
`endif

  generate
    if (CHAR_W == 9) begin : g_nine
      assign load_val = {glyph, col9};
    end else begin : g_eight
      logic unused_col9;
      assign unused_col9 = col9;
      assign load_val    = glyph;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_val;
    end else if (shift) begin
      sr <= {sr[CHAR_W-2:0], 1'b0};
    end
  end

  assign pix = sr[CHAR_W-1];

endmodule

// File: rtl/mda_char_fetch.sv
// Text-mode character fetch stage feeding the MDA attribute stage.
// Each character slot: fetch {attr, char} from VRAM (req/ack), look up the
// glyph row in the font ROM, then serialise it one dot per dot_en during the
// following slot. att_byte, row_addr, cursor and display_enable are delayed
// one slot so they line up with the dots. Also generates the CRTC char clock.
// Build option: MDA_LINEGFX_EN (ninth-column line graphics, in mda_dot_shifter).
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   dot_en                  one-clk strobe per dot period
//   ma, ra, de_in, cursor_in CRTC values for the next character
//   char_en                 CRTC advance pulse at the last dot of a cell
//   vram_req/addr/ack/data  VRAM read handshake
//   font_addr, font_data    font ROM lookup ({char, row[3:0]} -> glyph row)
//   pix, att_byte, row_addr, cursor, display_enable  dot-aligned outputs
//   fetch_miss              one-clk pulse when VRAM misses the deadline
module mda_char_fetch
  import mda_pkg::*;
#(
  parameter int CHAR_W  = CHAR_W_DEFAULT,
  parameter int MA_W    = 14,
  parameter int FONT_AW = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dot_en,
  input  logic [MA_W-1:0]    ma,
  input  logic [4:0]         ra,
  input  logic               de_in,
  input  logic               cursor_in,
  output logic               char_en,
  output logic               vram_req,
  output logic [MA_W-1:0]    vram_addr,
  input  logic               vram_ack,
  input  logic [15:0]        vram_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic               pix,
  output logic [7:0]         att_byte,
  output logic [4:0]         row_addr,
  output logic               cursor,
  output logic               display_enable,
  output logic               fetch_miss
);

  localparam logic [3:0] LAST_DOT = 4'(CHAR_W - 1);
  localparam logic [3:0] FONT_DOT = 4'(CHAR_W - 2);

  fetch_state_t state, state_nxt;

  logic [3:0] dot_cnt;
  logic       dot0;
  logic       deadline;
  logic       font_cap;
  logic       ack_take;
  logic       miss_now;

  // Fetch stage: the character being fetched during the current slot.
  logic [4:0] f_ra;
  logic       f_cursor;
  logic       f_de;
  logic [7:0] f_char;
  logic [7:0] f_attr;
  logic [7:0] f_glyph;

  assign dot0     = dot_en && (dot_cnt == 4'd0);
  assign deadline = dot_en && (dot_cnt == FETCH_DEADLINE_DOT);
  assign font_cap = dot_en && (dot_cnt == FONT_DOT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Dot 0 always starts a new slot: any finished fetch
  // retires and a request is launched only for displayed characters.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    if (dot0) begin
      state_nxt = de_in ? REQ : IDLE;
    end else begin
      case (state)
        REQ: begin
          // Ack takes priority over a deadline in the same clk.
          if (vram_ack)      state_nxt = FONT;
          else if (deadline) state_nxt = DONE;
        end
        FONT: if (font_cap) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    vram_req = (state == REQ);
    char_en  = dot_en && (dot_cnt == LAST_DOT);
    ack_take = (state == REQ) && vram_ack;
    miss_now = (state == REQ) && !vram_ack && deadline && !dot0;
  end

  // Dot counter, fetch stage and display-stage delay registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dot_cnt        <= '0;
      fetch_miss     <= 1'b0;
      vram_addr      <= '0;
      font_addr      <= '0;
      f_ra           <= '0;
      f_cursor       <= 1'b0;
      f_de           <= 1'b0;
      f_char         <= '0;
      f_attr         <= BLANK_ATTR;
      f_glyph        <= '0;
      att_byte       <= '0;
      row_addr       <= '0;
      cursor         <= 1'b0;
      display_enable <= 1'b0;
    end else begin
      fetch_miss <= miss_now;

      if (dot_en) begin
        dot_cnt <= (dot_cnt == LAST_DOT) ? 4'd0 : dot_cnt + 4'd1;
      end

      if (dot0) begin
        // Previous fetch moves to display, in step with the shifter load.
        att_byte       <= f_attr;
        row_addr       <= f_ra;
        cursor         <= f_cursor;
        display_enable <= f_de;
        // New fetch starts blank; a successful fetch fills it in later.
        f_ra           <= ra;
        f_cursor       <= cursor_in;
        f_de           <= de_in;
        f_char         <= '0;
        f_attr         <= BLANK_ATTR;
        f_glyph        <= '0;
        vram_addr      <= ma;
      end

      if (ack_take) begin
        f_char    <= vram_data[7:0];
        f_attr    <= vram_data[15:8];
        font_addr <= FONT_AW'({vram_data[7:0], f_ra[3:0]});
      end

      if ((state == FONT) && font_cap) begin
        f_glyph <= font_data;
      end
    end
  end

  mda_dot_shifter #(
    .CHAR_W (CHAR_W)
  ) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (dot0),
    .shift     (dot_en),
    .glyph     (f_glyph),
    .char_code (f_char),
    .pix       (pix)
  );

endmodule

// File: tb/tb_mda_char_fetch.sv
// Self-checking bench for mda_char_fetch (CHAR_W=9, dot_en every 2 clks).
// Expected display records are queued when a slot is driven and compared
// dot by dot during the following slot.
module tb_mda_char_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dot_en;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        de_in;
  logic        cursor_in;
  logic        char_en;
  logic        vram_req;
  logic [13:0] vram_addr;
  logic        vram_ack;
  logic [15:0] vram_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        pix;
  logic [7:0]  att_byte;
  logic [4:0]  row_addr;
  logic        cursor;
  logic        display_enable;
  logic        fetch_miss;

  always #5 clk = ~clk;

  mda_char_fetch #(
    .CHAR_W (9),
    .MA_W   (14),
    .FONT_AW(12)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dot_en         (dot_en),
    .ma             (ma),
    .ra             (ra),
    .de_in          (de_in),
    .cursor_in      (cursor_in),
    .char_en        (char_en),
    .vram_req       (vram_req),
    .vram_addr      (vram_addr),
    .vram_ack       (vram_ack),
    .vram_data      (vram_data),
    .font_addr      (font_addr),
    .font_data      (font_data),
    .pix            (pix),
    .att_byte       (att_byte),
    .row_addr       (row_addr),
    .cursor         (cursor),
    .display_enable (display_enable),
    .fetch_miss     (fetch_miss)
  );

  typedef struct {
    logic [8:0] pixels;
    logic [7:0] att;
    logic [4:0] row;
    logic       cur;
    logic       de;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_ce_cyc = -1;
  int          slot_no = 0;
  int          ack_delay = -1;
  logic        resp_ack = 1'b0;
  logic        spur_ack = 1'b0;
  logic [7:0]  rom_tab [256];

  assign vram_ack = resp_ack | spur_ack;

  always @(posedge clk) cyc <= cyc + 1;

  // VRAM responder: ack ack_delay clks after vram_req rises (never if < 0).
  initial begin : vram_model
    int age;
    bit sent;
    age  = 0;
    sent = 1'b0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (vram_req && !sent) begin
        age++;
        if (ack_delay >= 0 && age == ack_delay) begin
          resp_ack = 1'b1;
          sent     = 1'b1;
        end
      end else if (!vram_req) begin
        age  = 0;
        sent = 1'b0;
      end
    end
  end

  // Font ROM: glyph row depends on char code only.
  initial begin : font_model
    font_data = 8'h00;
    forever begin
      @(negedge clk);
      font_data = rom_tab[font_addr[11:4]];
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic col9_of(input logic [7:0] ch, input logic [7:0] g);
`ifdef MDA_LINEGFX_EN
    return (ch[7:5] == 3'b110) ? g[0] : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t blank_rec();
    exp_t e;
    e.pixels = '0;
    e.att    = '0;
    e.row    = '0;
    e.cur    = 1'b0;
    e.de     = 1'b0;
    return e;
  endfunction

  // Drive one 9-dot character slot and check the slot currently displayed.
  task automatic do_slot(input logic de, input logic [13:0] addr, input logic [7:0] ch,
                         input logic [7:0] attr, input logic [4:0] r, input logic cur,
                         input int ack_dly, input logic [7:0] glyph, input int spur_k);
    exp_t cur_e, nxt_e;
    logic ok, miss;
    ok   = de && (ack_dly >= 0) && (ack_dly <= 10);
    miss = de && !ok;
    nxt_e.pixels = ok ? {glyph, col9_of(ch, glyph)} : 9'h000;
    nxt_e.att    = ok ? attr : 8'h00;
    nxt_e.row    = r;
    nxt_e.cur    = cur;
    nxt_e.de     = de;
    if (sb.size() == 0) cur_e = blank_rec();
    else cur_e = sb.pop_front();
    sb.push_back(nxt_e);
    slot_no++;

    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        de_in     = de;
        ma        = addr;
        ra        = r;
        cursor_in = cur;
        ack_delay = ack_dly;
        vram_data = {attr, ch};
        rom_tab[ch] = glyph;
      end
      dot_en = 1'b1;
      if (k == spur_k) spur_ack = 1'b1;
      #1;
      check($sformatf("char_en s%0d d%0d", slot_no, k), 16'(char_en), 16'(k == 8));
      if (k == 8) begin
        if (last_ce_cyc >= 0)
          check($sformatf("char_en_gap s%0d", slot_no), 16'(cyc - last_ce_cyc), 16'd18);
        last_ce_cyc = cyc;
      end
      @(posedge clk);
      #1;
      check($sformatf("pix s%0d d%0d", slot_no, k), 16'(pix), 16'(cur_e.pixels[8-k]));
      check($sformatf("att s%0d d%0d", slot_no, k), 16'(att_byte), 16'(cur_e.att));
      check($sformatf("row s%0d d%0d", slot_no, k), 16'(row_addr), 16'(cur_e.row));
      check($sformatf("cursor s%0d d%0d", slot_no, k), 16'(cursor), 16'(cur_e.cur));
      check($sformatf("de s%0d d%0d", slot_no, k), 16'(display_enable), 16'(cur_e.de));
      check($sformatf("miss s%0d d%0d", slot_no, k), 16'(fetch_miss), 16'(miss && k == 5));
      if (k == 0) begin
        check($sformatf("req s%0d", slot_no), 16'(vram_req), 16'(de));
        if (de) check($sformatf("vaddr s%0d", slot_no), 16'(vram_addr), 16'(addr));
      end
      if (miss && k == 4) check($sformatf("req_hold s%0d", slot_no), 16'(vram_req), 16'd1);
      if (miss && k == 5) check($sformatf("req_drop s%0d", slot_no), 16'(vram_req), 16'd0);
      if (!de && k == 8) check($sformatf("no_req s%0d", slot_no), 16'(vram_req), 16'd0);
      if (ok && k == 7) check($sformatf("font_addr s%0d", slot_no), 16'(font_addr), 16'({ch, r[3:0]}));
      @(negedge clk);
      dot_en   = 1'b0;
      spur_ack = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_tab[i] = 8'h00;
    reset_n   = 1'b0;
    dot_en    = 1'b0;
    ma        = '0;
    ra        = '0;
    de_in     = 1'b0;
    cursor_in = 1'b0;
    vram_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst pix", 16'(pix), 16'd0);
    check("rst req", 16'(vram_req), 16'd0);
    check("rst att", 16'(att_byte), 16'd0);
    check("rst font_addr", 16'(font_addr), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(blank_rec());

    // Steady state: char 0x41, row 7E, attr 07, ack 3 clks after req.
    do_slot(1'b1, 14'h0100, 8'h41, 8'h07, 5'd0, 1'b0, 3, 8'h7E, -1);
    do_slot(1'b1, 14'h0101, 8'h41, 8'h07, 5'd1, 1'b0, 3, 8'h7E, -1);
    // Deadline miss, with a late spurious ack after the deadline.
    do_slot(1'b1, 14'h0102, 8'h41, 8'h07, 5'd2, 1'b0, -1, 8'h7E, 6);
    // Display disabled, spurious ack while idle.
    do_slot(1'b0, 14'h0103, 8'h41, 8'h07, 5'd3, 1'b0, 3, 8'h7E, 2);
    // Line graphics and its non-graphics counterpart.
    do_slot(1'b1, 14'h0104, 8'hC4, 8'h0F, 5'd4, 1'b0, 3, 8'hFF, -1);
    do_slot(1'b1, 14'h0105, 8'h41, 8'h70, 5'd5, 1'b0, 3, 8'hFF, -1);
    // Ack in the same clk as the deadline: ack wins.
    do_slot(1'b1, 14'h0106, 8'h42, 8'h70, 5'd6, 1'b1, 10, 8'h81, -1);
    do_slot(1'b1, 14'h0107, 8'h43, 8'h01, 5'd7, 1'b0, 4, 8'h3C, -1);

    // Reset in the middle of a request.
    @(negedge clk);
    de_in     = 1'b1;
    ma        = 14'h0200;
    ack_delay = -1;
    dot_en    = 1'b1;
    @(negedge clk);
    dot_en = 1'b0;
    @(negedge clk);
    check("pre_rst req", 16'(vram_req), 16'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst req", 16'(vram_req), 16'd0);
    check("mid_rst pix", 16'(pix), 16'd0);
    check("mid_rst att", 16'(att_byte), 16'd0);
    check("mid_rst row", 16'(row_addr), 16'd0);
    check("mid_rst cursor", 16'(cursor), 16'd0);
    check("mid_rst de", 16'(display_enable), 16'd0);
    check("mid_rst vaddr", 16'(vram_addr), 16'd0);
    check("mid_rst font_addr", 16'(font_addr), 16'd0);
    check("mid_rst miss", 16'(fetch_miss), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    sb.push_back(blank_rec());
    last_ce_cyc = -1;

    // Counter restarts at 0; alignment of row/cursor with the pixel load.
    do_slot(1'b1, 14'h0300, 8'h41, 8'h07, 5'd12, 1'b1, 3, 8'h7E, -1);
    do_slot(1'b1, 14'h0301, 8'hC4, 8'h07, 5'd3, 1'b0, 2, 8'hFF, -1);
    do_slot(1'b0, 14'h0302, 8'h00, 8'h00, 5'd0, 1'b0, -1, 8'h00, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mda_char_fetch.md
Name: mda_char_fetch

Overview:
- Text-mode character pipeline stage directly upstream of the MDA attribute stage.
- Per character slot it:
  - fetches the character/attribute word from VRAM over a req/ack handshake;
  - looks up the glyph row in the font ROM;
  - serialises it into 9 dots per character.
- Delivers pix, att_byte, row_addr, cursor and display_enable to the attribute stage, all aligned to the same dot.
- Also generates the character-clock enable that advances the CRTC.

Parameters:
- CHAR_W, 9, dots per character cell (legal values 8 or 9).
- MA_W, 14, CRTC memory-address width (equals vram_addr width).
- FONT_AW, 12, font ROM address width: {char_code[7:0], row[3:0]}.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- dot_en  in  1  one-clk strobe per dot period; all dot-level state advances only on dot_en
- ma  in  MA_W  CRTC memory address of the next character
- ra  in  5  CRTC row address
- de_in  in  1  CRTC display enable for the next character
- cursor_in  in  1  CRTC cursor match for the next character
- char_en  out  1  one-clk pulse on dot_en when dot_cnt==CHAR_W-1; advances the CRTC
- vram_req  out  1  read request
- vram_addr  out  MA_W  word address, held stable while vram_req is high
- vram_ack  in  1  one-clk data-valid strobe
- vram_data  in  16  {attribute[15:8], char_code[7:0]}
- font_addr  out  FONT_AW  registered font ROM address
- font_data  in  8  glyph row, MSB = leftmost dot; valid 1 clk after font_addr changes
- pix  out  1  serial dot to the attribute stage
- att_byte  out  8  attribute of the character being shown
- row_addr  out  5  ra, delayed one slot
- cursor  out  1  cursor_in, delayed one slot
- display_enable  out  1  de_in, delayed one slot
- fetch_miss  out  1  one-clk pulse when a fetch deadline is missed

Behaviour:
- Reset: all outputs 0; dot_cnt=0; shift register=0; fetch FSM in IDLE.
- dot_cnt:
  - Counts 0..CHAR_W-1 on dot_en, then wraps to 0.
  - char_en pulses at the wrap.
- Pipeline depth is exactly one character slot: the character sampled at dot 0 of slot N is displayed during slot N+1.
- Dot 0 of each slot (on dot_en):
  - Samples ma, ra, de_in and cursor_in into a fetch stage.
  - The previous fetch stage moves into the display stage: att_byte, row_addr, cursor and display_enable update together, and the shift register loads.
- Fetch FSM:
  - IDLE -> REQ at dot 0 when de_in=1. vram_req rises the next clk; vram_addr = sampled ma.
  - If de_in=0 at dot 0, no request is issued and the slot is loaded blank (char 0x00, attr 0x00).
  - REQ -> FONT on vram_ack: latch vram_data; drop vram_req the same clk; drive font_addr = {char_code, ra[3:0]} the next clk.
  - FONT -> DONE when font_data is captured at dot CHAR_W-2.
  - DONE -> IDLE at dot 0.
- Deadline:
  - If no ack has arrived by the dot_en of dot 5, drop vram_req, pulse fetch_miss and load a blank cell (glyph 0, attr 0x00).
  - A vram_ack arriving outside REQ is ignored.
  - If ack and the deadline fall in the same clk, ack wins.
- Shift register (CHAR_W bits):
  - Loaded at dot 0 with {glyph[7:0], col9}; shifts left on each dot_en; pix = MSB.
  - col9 = 0 unless the optional feature is present.
  - When CHAR_W=8, col9 is dropped.
- Synchronous reset mid-fetch drops vram_req in the same clk edge and aborts the slot.

Optional Feature:
- Macro: MDA_LINEGFX_EN.
- Defined: col9 = glyph bit0 when char_code[7:5]==3'b110 (codes 0xC0–0xDF), so box-drawing characters join horizontally; col9 = 0 otherwise.
- Undefined: col9 is always 0.

Decomposition:
- Package mda_pkg holds:
  - CHAR_W_DEFAULT;
  - LINEGFX_LO/HI constants (0xC0, 0xDF);
  - BLANK_ATTR (8'h00);
  - the FETCH_DEADLINE_DOT constant (5);
  - the fetch-state enum type (IDLE, REQ, FONT, DONE).
- One sub-module, mda_dot_shifter: CHAR_W-bit load/shift register with col9 logic.
- The fetch FSM and delay stage stay in the top module.

Test Plan:
- Steady state: dot_en every 2 clks, ack 3 clks after req, char 0x41 with font row 8'h7E, attr 0x07 → next slot pix=0,1,1,1,1,1,1,0,0; att_byte=0x07; char_en once every 18 clks.
- Late ack: ack never arrives → vram_req falls at dot 5, fetch_miss pulses once, next slot pix all 0 and att_byte=0x00.
- Line graphics: char 0xC4 with row 8'hFF → dot 8 = 1 with MDA_LINEGFX_EN defined, 0 without; char 0x41 with row 8'hFF → dot 8 = 0 in both builds.
- de_in=0 at dot 0 → no vram_req; next slot display_enable=0 and pix=0; spurious ack injected → ignored.
- Reset mid-REQ: reset_n=0 while vram_req=1 → vram_req=0 and all outputs 0 the next clk; after release, dot_cnt restarts at 0.
- Alignment: ra=12 with cursor_in=1 at slot N → row_addr=12 and cursor=1 exactly during slot N+1's 9 dots, changing at the same edge as the shift-register load.
